microsequencer_stack: RTL
=========================

Name: microsequencer_stack

Overview:
Parametrised next-address generator for the microprogrammed control unit. It replaces the fixed 7-bit adder, incrementer register, next-state selector, condition mux and inverter with one registered sequencer. It adds N-way condition select, conditional wait (MOC polling), and a microsubroutine call/return stack. It drives the microaddress into the external combinational microstore and consumes that microword's sequencing fields in the same cycle.

Parameters:
AW, 7, microaddress width
NCOND, 4, number of condition inputs (bit 0 = MOC, bit 1 = COND by convention)
SW, 2, cond_sel width; must satisfy 2**SW >= NCOND
DEPTH, 4, call-stack entries (>=1)
RESET_ADDR, 0, microaddress after reset, FETCH and empty-RET

Ports:
Clk  in  1  clock, rising edge
Clr  in  1  synchronous reset, active-high
enc_addr  in  AW  decoded instruction entry address from the IR encoder
cond_in  in  NCOND  condition inputs
seq_op  in  3  sequencing op from the current microword
cond_sel  in  SW  condition index from the current microword
inv  in  1  invert selected condition
cr_addr  in  AW  branch/call target from the current microword
hold  in  1  freeze sequencer for this cycle
upa  out  AW  current microaddress, registered
stack_full  out  1  sp == DEPTH
stack_empty  out  1  sp == 0
stack_err  out  1  sticky overflow/underflow flag
sp  out  $clog2(DEPTH+1)  stack occupancy

Behaviour:
- Reset on a Clk edge with Clr=1: upa=RESET_ADDR, sp=0, stack_err=0, stack contents don't-care. Clr takes priority over hold and seq_op.
- Condition: c = (cond_sel < NCOND ? cond_in[cond_sel] : 0) ^ inv. Combinational.
- The next address is computed combinationally from the current upa's fields and loaded at the next edge. One-cycle latency per microinstruction.
- inc = upa+1, modulo 2**AW. Max address wraps to 0.
- hold=1 (and Clr=0): upa, sp, stack and stack_err are all unchanged.
- seq_op decode (Clr=0, hold=0):
  - 000 JUMP_ENC: upa<=enc_addr
  - 001 JUMP: upa<=cr_addr
  - 010 INC: upa<=inc
  - 011 CJUMP: upa<= c ? cr_addr : inc
  - 100 CWAIT: upa<= c ? inc : upa (stay until condition, e.g. MOC)
  - 101 CALL: push inc; upa<=cr_addr
  - 110 RET: upa<=top of stack; pop
  - 111 FETCH: upa<=RESET_ADDR
- Stack is LIFO. Push writes entry[sp] and sets sp+1. Pop reads entry[sp-1] and sets sp-1. Return address is read before the pointer moves.
- CALL when sp==DEPTH: no push, sp unchanged, jump to cr_addr still taken, stack_err<=1.
- RET when sp==0: upa<=RESET_ADDR, sp stays 0, stack_err<=1.
- stack_err clears only on Clr.
- Only one stack operation per cycle; CALL and RET are mutually exclusive by encoding.
- No X propagation: undefined inputs are not allowed. Unused cond bits are ignored.

Test Plan:
- Reset: Clr=1 for 2 edges with seq_op=010 -> upa=0, sp=0, stack_empty=1, stack_err=0. Release with INC for 3 edges -> upa=1,2,3.
- Wrap/jump: JUMP cr_addr=127, then INC -> upa=127 then 0. JUMP_ENC enc_addr=67 -> upa=67. FETCH -> upa=0.
- MOC wait: upa=3, seq_op=100, cond_sel=0, cond_in[0]=0 for 4 edges -> upa stays 3. cond_in[0]=1 -> upa=4. Repeat with inv=1 -> advances while MOC=0.
- Conditional jump: CJUMP cr_addr=80, cond_sel=1. COND=1 -> upa=80. COND=0 at upa=80 -> upa=81. cond_sel=3 with NCOND=3, inv=0 -> not taken.
- Nested call/return: from upa=10 CALL 40, at 40 CALL 60, at 60 RET -> upa=41, sp=1. RET -> upa=11, sp=0, stack_err=0.
- Errors and hold: DEPTH=4, 5 consecutive CALLs -> sp=4, stack_full=1, stack_err=1, fifth jump taken. Then 4 RETs unwind correctly. Fifth RET -> upa=0, sp=0. hold=1 during CALL -> no change. Clr mid-stack -> sp=0, stack_err=0.

Source files
------------

// File: rtl/microsequencer_stack.sv
// Registered next-microaddress generator with N-way condition select,
// conditional wait and a LIFO microsubroutine call/return stack.
module microsequencer_stack #(
  parameter int AW         = 7,
  parameter int NCOND      = 4,
  parameter int SW         = 2,
  parameter int DEPTH      = 4,
  parameter int RESET_ADDR = 0,
  localparam int SPW       = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [AW-1:0]    enc_addr,
  input  logic [NCOND-1:0] cond_in,
  input  logic [2:0]       seq_op,
  input  logic [SW-1:0]    cond_sel,
  input  logic             inv,
  input  logic [AW-1:0]    cr_addr,
  input  logic             hold,
  output logic [AW-1:0]    upa,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err,
  output logic [SPW-1:0]   sp
);

  localparam int CW = 2 ** SW;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]  RST_A   = AW'(RESET_ADDR);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  localparam logic [2:0] OP_JUMP_ENC = 3'b000;
  localparam logic [2:0] OP_JUMP     = 3'b001;
  localparam logic [2:0] OP_INC      = 3'b010;
  localparam logic [2:0] OP_CJUMP    = 3'b011;
  localparam logic [2:0] OP_CWAIT    = 3'b100;
  localparam logic [2:0] OP_CALL     = 3'b101;
  localparam logic [2:0] OP_RET      = 3'b110;
  localparam logic [2:0] OP_FETCH    = 3'b111;

  logic [AW-1:0]  stack_mem [DEPTH];
  logic [CW-1:0]  cond_pad;
  logic           c;
  logic [AW-1:0]  inc;
  logic [AW-1:0]  upa_nxt;
  logic           push;
  logic           pop;
  logic           err_set;
  logic [SPW-1:0] sp_m1;
  logic [IW-1:0]  push_idx;
  logic [IW-1:0]  pop_idx;

  // Zero-padding makes selects beyond NCOND read as 0 without an out-of-range index.
  assign cond_pad = CW'(cond_in);
  assign c        = cond_pad[cond_sel] ^ inv;
  assign inc      = upa + AW'(1);

  assign sp_m1    = sp - SPW'(1);
  assign push_idx = sp[IW-1:0];
  assign pop_idx  = sp_m1[IW-1:0];

  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);

  always_comb begin
    upa_nxt = upa;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    unique case (seq_op)
      OP_JUMP_ENC: upa_nxt = enc_addr;
      OP_JUMP:     upa_nxt = cr_addr;
      OP_INC:      upa_nxt = inc;
      OP_CJUMP:    upa_nxt = c ? cr_addr : inc;
      OP_CWAIT:    upa_nxt = c ? inc : upa;
      OP_CALL: begin
        upa_nxt = cr_addr;
        if (stack_full) err_set = 1'b1;
        else            push    = 1'b1;
      end
      OP_RET: begin
        if (stack_empty) begin
          upa_nxt = RST_A;
          err_set = 1'b1;
        end else begin
          upa_nxt = stack_mem[pop_idx];
          pop     = 1'b1;
        end
      end
      OP_FETCH:    upa_nxt = RST_A;
      default:     upa_nxt = upa;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      upa       <= RST_A;
      sp        <= '0;
      stack_err <= 1'b0;
    end else if (!hold) begin
      upa <= upa_nxt;
      if (push) begin
        stack_mem[push_idx] <= inc;
        sp                  <= sp + SPW'(1);
      end else if (pop) begin
        sp <= sp_m1;
      end
      if (err_set) stack_err <= 1'b1;
    end
  end

endmodule
